// File: rtl/wishbone_wrr_arbiter.sv
// Round-robin Wishbone arbiter for four masters, with an ACK-count fairness quota.
// Optional stalled-cycle watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wishbone_wrr_arbiter #(
    parameter int unsigned QUOTA   = 8,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] CYC_I,
    input  logic       ACK_I,
    output logic [1:0] GNT,
    output logic [3:0] GNT_mux,
    output logic       CYC,
    output logic       QUOTA_EXP,
    output logic       ERR_O
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StAbort = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] QuotaMax = CNT_W'(QUOTA);

    state_e           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;

    // The current grant is the round-robin pointer: it is scanned last.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] req);
        logic [1:0] pick;
        logic [1:0] cand;
        pick = ptr;
        for (int i = 4; i >= 1; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) pick = cand;
        end
        return pick;
    endfunction

    assign GNT       = gnt_q;
    assign GNT_mux   = 4'b0001 << gnt_q;
    assign CYC       = (state_q == StBusy) & CYC_I[gnt_q] & ~RST;
    assign QUOTA_EXP = (state_q == StBusy) & (ack_cnt_q == QuotaMax) & (|(CYC_I & ~GNT_mux));

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;

    assign ERR_O = err_q;
`else
    assign ERR_O = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ack_cnt_d = ack_cnt_q;
`ifdef WB_ARB_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                ack_cnt_d = '0;
`ifdef WB_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                if (|CYC_I) begin
                    gnt_d   = rr_pick(gnt_q, CYC_I);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (CYC && ACK_I && (ack_cnt_q != QuotaMax)) begin
                    ack_cnt_d = ack_cnt_q + CNT_W'(1);
                end
`ifdef WB_ARB_TIMEOUT_EN
                if (CYC) begin
                    if (ACK_I) begin
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q == TimeoutLast) begin
                        err_d   = 1'b1;
                        state_d = StAbort;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
`endif
                // Release never coincides with an abort: CYC is low once CYC_I[GNT] drops.
                if (!CYC_I[gnt_q]) state_d = StIdle;
            end
            StAbort: begin
`ifdef WB_ARB_TIMEOUT_EN
                if (!CYC_I[gnt_q]) state_d = StIdle;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            gnt_q     <= 2'd0;
            ack_cnt_q <= '0;
`ifdef WB_ARB_TIMEOUT_EN
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ack_cnt_q <= ack_cnt_d;
`ifdef WB_ARB_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_wishbone_wrr_arbiter.sv
// Directed bench for wishbone_wrr_arbiter; grant events are checked against a scoreboard queue.
module tb_wishbone_wrr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ack;
    logic [3:0] cyc_i;
    logic [1:0] gnt;
    logic [3:0] gnt_mux;
    logic       cyc;
    logic       qexp;
    logic       err;

    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] exp_q[$];
    logic       cyc_prev = 1'b0;

    wishbone_wrr_arbiter #(
        .QUOTA  (8),
        .TIMEOUT(4),
        .CNT_W  (8)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .CYC_I    (cyc_i),
        .ACK_I    (ack),
        .GNT      (gnt),
        .GNT_mux  (gnt_mux),
        .CYC      (cyc),
        .QUOTA_EXP(qexp),
        .ERR_O    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Each new bus ownership (CYC rising) must match the next expected grant.
    always @(posedge clk) begin
        #1;
        if (cyc && !cyc_prev) begin
            if (exp_q.size() == 0) check("grant_unexpected", {6'd0, gnt}, 8'hff);
            else check("grant_sb", {6'd0, gnt}, {6'd0, exp_q.pop_front()});
        end
        cyc_prev = cyc;
    end

    task automatic serve(input int m, input int nacks, input logic [3:0] req_after,
                         input logic [1:0] next_m);
        ack = 1'b1;
        repeat (nacks) tick;
        ack = 1'b0;
        cyc_i[m] = 1'b0;
        tick;
        check("idle_cyc", cyc, 0);
        check("idle_gnt", gnt, m[7:0]);
        cyc_i = req_after;
        exp_q.push_back(next_m);
        tick;
        check("next_gnt", gnt, next_m);
        check("next_cyc", cyc, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed still running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst   = 1'b1;
        ack   = 1'b0;
        cyc_i = 4'b1111;
        @(negedge clk);
        tick;
        check("rst_gnt", gnt, 0);
        check("rst_mux", gnt_mux, 4'b0001);
        check("rst_cyc", cyc, 0);
        check("rst_qexp", qexp, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        exp_q.push_back(2'd1);
        tick;
        check("first_gnt", gnt, 1);
        check("first_mux", gnt_mux, 4'b0010);
        check("first_cyc", cyc, 1);

        // Rotation with everyone requesting.
        serve(1, 2, 4'b1111, 2'd2);
        serve(2, 2, 4'b1111, 2'd3);
        serve(3, 2, 4'b1111, 2'd0);
        serve(0, 2, 4'b1111, 2'd1);

        // Quota on master 2.
        serve(1, 1, 4'b0100, 2'd2);
        ack = 1'b1;
        repeat (7) tick;
        ack = 1'b0;
        cyc_i = 4'b0101;
        #1 check("quota_at7", qexp, 0);
        cyc_i = 4'b0100;
        ack = 1'b1;
        tick;
        ack = 1'b0;
        #1 check("quota_alone", qexp, 0);
        cyc_i = 4'b0101;
        #1 check("quota_same_cycle", qexp, 1);
        ack = 1'b1;
        tick;
        ack = 1'b0;
        check("quota_sat", qexp, 1);
        cyc_i = 4'b0001;
        tick;
        check("quota_idle", qexp, 0);
        check("quota_idle_cyc", cyc, 0);
        exp_q.push_back(2'd0);
        tick;
        check("quota_next_gnt", gnt, 0);
        check("quota_cleared", qexp, 0);

        // Lone requester re-granted after one idle cycle.
        cyc_i = 4'b0000;
        tick;
        check("lone_idle0", cyc, 0);
        cyc_i = 4'b1000;
        exp_q.push_back(2'd3);
        tick;
        check("lone_gnt0", gnt, 3);
        for (int p = 0; p < 3; p++) begin
            cyc_i = 4'b0000;
            tick;
            check("lone_idle", cyc, 0);
            cyc_i = 4'b1000;
            exp_q.push_back(2'd3);
            tick;
            check("lone_gnt", gnt, 3);
            check("lone_cyc", cyc, 1);
        end
        cyc_i = 4'b1011;
        tick;
        check("nongranted_gnt", gnt, 3);
        check("nongranted_cyc", cyc, 1);
        cyc_i = 4'b0011;
        tick;
        exp_q.push_back(2'd0);
        tick;
        check("wrap_gnt", gnt, 0);

        // Stalled master 1, no ACK.
        cyc_i = 4'b0010;
        tick;
        exp_q.push_back(2'd1);
        tick;
        check("stall_gnt", gnt, 1);
`ifdef WB_ARB_TIMEOUT_EN
        repeat (3) tick;
        check("wd_pre_err", err, 0);
        check("wd_pre_cyc", cyc, 1);
        tick;
        check("wd_err", err, 1);
        check("wd_err_cyc", cyc, 0);
        tick;
        check("wd_hold_err", err, 0);
        check("wd_hold_cyc", cyc, 0);
        cyc_i = 4'b0000;
        tick;
        check("wd_idle_err", err, 0);
        check("wd_idle_cyc", cyc, 0);
`else
        repeat (6) tick;
        check("nowd_err", err, 0);
        check("nowd_cyc", cyc, 1);
        cyc_i = 4'b0000;
        tick;
        check("nowd_idle_cyc", cyc, 0);
`endif

        // Reset in the middle of a cycle.
        cyc_i = 4'b0100;
        exp_q.push_back(2'd2);
        tick;
        check("mid_gnt", gnt, 2);
        ack = 1'b1;
        repeat (5) tick;
        ack = 1'b0;
        rst = 1'b1;
        #1 check("mid_rst_comb_cyc", cyc, 0);
        tick;
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_mux", gnt_mux, 4'b0001);
        check("mid_rst_cyc", cyc, 0);
        check("mid_rst_qexp", qexp, 0);
        check("mid_rst_err", err, 0);
        rst = 1'b0;
        exp_q.push_back(2'd2);
        tick;
        check("post_rst_gnt", gnt, 2);
        check("post_rst_cyc", cyc, 1);
        cyc_i = 4'b0000;
        tick;
        tick;
        check("sb_drain", 8'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
